// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment pattern receiver: FSM states, glyph table,
// io_in/io_out bit positions and the frame timer width.
package seg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_ABORT   = 3'd3,
        ST_WAITEND = 3'd4
    } state_e;

    localparam int TIMER_W = 8;

    // Common-cathode patterns, bit6=g ... bit0=a, indexed by hex digit.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] GLYPH_7_ALT = 7'h27;
    localparam logic [6:0] GLYPH_9_ALT = 7'h67;

    localparam int IO_CLK   = 0;
    localparam int IO_RST   = 1;
    localparam int IO_SDATA = 2;
    localparam int IO_SSTB  = 3;
    localparam int IO_SFRM  = 4;

    localparam int OUT_VALID = 4;
    localparam int OUT_ERR   = 5;
    localparam int OUT_DONE  = 6;
    localparam int OUT_BUSY  = 7;

endpackage

// File: rtl/seg_decode.sv
// Combinational glyph lookup: 7-bit segment pattern to {legal, hex digit}.
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       legal_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b0;
        digit_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == GLYPH[i]) begin
                legal_o = 1'b1;
                digit_o = 4'(i);
            end
        end
        if (pattern_i == GLYPH_7_ALT) begin
            legal_o = 1'b1;
            digit_o = 4'h7;
        end
        if (pattern_i == GLYPH_9_ALT) begin
            legal_o = 1'b1;
            digit_o = 4'h9;
        end
    end

endmodule

// File: rtl/seg_pattern_rx.sv
// Serial 7-segment pattern receiver: synchronizes the framed bit stream, shifts in
// segments g..a, decodes the glyph and reports value/valid/err/done/busy on io_out.
module seg_pattern_rx
    import seg_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk;
    logic rst;
    assign clk = io_in[IO_CLK];
    assign rst = io_in[IO_RST];

    logic unused_io;
    assign unused_io = ^io_in[7:5];

    logic [SYNC_STAGES-1:0] sdata_sync_q, sstb_sync_q, sfrm_sync_q;
    logic                   sstb_prev_q, sfrm_prev_q, stb_edge_q;
    logic                   sdata_s, sstb_s, sfrm_s, frm_rise;

    assign sdata_s  = sdata_sync_q[SYNC_STAGES-1];
    assign sstb_s   = sstb_sync_q[SYNC_STAGES-1];
    assign sfrm_s   = sfrm_sync_q[SYNC_STAGES-1];
    assign frm_rise = sfrm_s & ~sfrm_prev_q;

    // The strobe edge is registered once more so a rise is acted on SYNC_STAGES+1 edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdata_sync_q <= '0;
            sstb_sync_q  <= '0;
            sfrm_sync_q  <= '0;
            sstb_prev_q  <= 1'b0;
            sfrm_prev_q  <= 1'b0;
            stb_edge_q   <= 1'b0;
        end else begin
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], io_in[IO_SDATA]};
            sstb_sync_q  <= {sstb_sync_q[SYNC_STAGES-2:0], io_in[IO_SSTB]};
            sfrm_sync_q  <= {sfrm_sync_q[SYNC_STAGES-2:0], io_in[IO_SFRM]};
            sstb_prev_q  <= sstb_s;
            sfrm_prev_q  <= sfrm_s;
            stb_edge_q   <= sstb_s & ~sstb_prev_q;
        end
    end

    state_e             state_q, state_d;
    logic [6:0]         shift_q, shift_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         value_q, value_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               dec_legal;
    logic [3:0]         dec_digit;

    seg_decode u_decode (
        .pattern_i (shift_q),
        .legal_o   (dec_legal),
        .digit_o   (dec_digit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        value_d = value_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frm_rise) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                // A strobe takes priority over both frame drop and timeout.
                if (stb_edge_q) begin
                    shift_d = {shift_q[5:0], sdata_s};
                    cnt_d   = cnt_q + 3'd1;
                    timer_d = '0;
                    if (cnt_q == 3'd6) begin
                        state_d = ST_DECODE;
                    end
                end else if (!sfrm_s) begin
                    state_d = ST_ABORT;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    state_d = ST_ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    value_d = dec_digit;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_WAITEND;
            end
            ST_ABORT: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = ST_WAITEND;
            end
            ST_WAITEND: begin
                if (!sfrm_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        io_out            = '0;
        io_out[3:0]       = value_q;
        io_out[OUT_VALID] = valid_q;
        io_out[OUT_ERR]   = err_q;
        io_out[OUT_DONE]  = done_q;
        io_out[OUT_BUSY]  = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Scoreboard bench for seg_pattern_rx: directed frames push the expected io_out at
// the done pulse; a monitor pops and compares on every done pulse.
module tb_seg_pattern_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sdata = 1'b0;
  logic       sstb = 1'b0;
  logic       sfrm = 1'b0;
  logic [2:0] spare = 3'b101;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {spare, sfrm, sstb, sdata, rst, clk};

  seg_pattern_rx dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] m_value = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Independent glyph model: returns {legal, digit}.
  function automatic logic [4:0] model_decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h10; 7'h06: return 5'h11; 7'h5B: return 5'h12; 7'h4F: return 5'h13;
      7'h66: return 5'h14; 7'h6D: return 5'h15; 7'h7D: return 5'h16; 7'h07: return 5'h17;
      7'h7F: return 5'h18; 7'h6F: return 5'h19; 7'h77: return 5'h1A; 7'h7C: return 5'h1B;
      7'h39: return 5'h1C; 7'h5E: return 5'h1D; 7'h79: return 5'h1E; 7'h71: return 5'h1F;
      7'h27: return 5'h17; 7'h67: return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && io_out[6]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %02h expected no done pulse", io_out);
      end else begin
        check("done_frame", io_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdata = b;
    tick(1);
    sstb = 1'b1;
    tick(4);
    sstb = 1'b0;
    tick(3);
  endtask

  task automatic push_expected();
    exp_q.push_back({1'b1, 1'b1, m_err, m_valid, m_value});
  endtask

  function automatic logic [7:0] idle_status();
    return {3'b000, m_err, m_valid, m_value};
  endfunction

  task automatic run_frame(input logic [6:0] p, input string name);
    logic [4:0] d;
    d = model_decode(p);
    if (d[4]) begin
      m_value = d[3:0];
      m_valid = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b1;
    end
    push_expected();
    sfrm = 1'b1;
    tick(4);
    for (int i = 6; i >= 0; i--) send_bit(p[i]);
    tick(4);
    sfrm = 1'b0;
    tick(8);
    check(name, io_out, idle_status());
  endtask

  task automatic expect_abort();
    m_valid = 1'b0;
    m_err   = 1'b1;
    push_expected();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] p;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_state", io_out, 8'h00);
    tick(20);
    check("idle_20", io_out, 8'h00);

    run_frame(7'h5B, "frame_5b_status");
    check("frame_5b_exact", io_out, 8'h12);
    run_frame(7'h71, "frame_71_status");
    run_frame(7'h00, "frame_00_status");
    check("frame_00_exact", io_out, 8'h2F);

    // Framing error: sfrm drops after four bits.
    expect_abort();
    p = 7'h06;
    sfrm = 1'b1;
    tick(4);
    for (int i = 6; i >= 3; i--) send_bit(p[i]);
    sfrm = 1'b0;
    tick(8);
    check("abort_status", io_out, idle_status());

    run_frame(7'h3F, "frame_3f_status");

    // Timeout: 300-cycle strobe gap after bit 3, then stray strobes before sfrm falls.
    expect_abort();
    p = 7'h4F;
    sfrm = 1'b1;
    tick(4);
    for (int i = 6; i >= 4; i--) send_bit(p[i]);
    tick(200);
    check("no_early_timeout", {io_out[7], io_out[6], io_out[5]}, {5'b0, 3'b100});
    tick(100);
    for (int i = 3; i >= 2; i--) send_bit(p[i]);
    check("timeout_waitend", {io_out[7], io_out[5], io_out[4]}, {5'b0, 3'b110});
    sfrm = 1'b0;
    tick(8);
    check("timeout_status", io_out, idle_status());

    // Reset during bit 5.
    p = 7'h7F;
    sfrm = 1'b1;
    tick(4);
    for (int i = 6; i >= 3; i--) send_bit(p[i]);
    sdata = p[2];
    tick(1);
    sstb = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sfrm = 1'b0;
    sstb = 1'b0;
    m_value = 4'h0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    check("reset_midframe", io_out, 8'h00);
    tick(10);
    check("reset_quiet", io_out, 8'h00);

    run_frame(7'h07, "frame_07_status");
    check("frame_07_exact", io_out, 8'h17);

    tick(10);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
